// File: rtl/gelato_types.sv
// rtl/gelato_types.sv - shared widths and fetch request types for the fetch scheduler
package gelato_types;

  localparam int WARP_NUM        = 8;
  localparam int WARP_NUM_WIDTH  = 3;
  localparam int PC_WIDTH        = 32;
  localparam int SPLIT_NUM_WIDTH = 5;

  typedef logic [WARP_NUM_WIDTH-1:0]  warp_num_t;
  typedef logic [PC_WIDTH-1:0]        pc_t;
  typedef logic [SPLIT_NUM_WIDTH-1:0] split_table_num_t;

  typedef struct packed {
    warp_num_t        warp_num;
    pc_t              pc;
    split_table_num_t split_table_num;
  } fetch_req_t;

endpackage

// File: rtl/gelato_fetch_scheduler_if.sv
// rtl/gelato_fetch_scheduler_if.sv - PC-table inputs and fetch-request handshake of the scheduler
interface gelato_fetch_scheduler_if;
  import gelato_types::*;

  logic [WARP_NUM-1:0]                 pt_valid;
  logic [WARP_NUM*PC_WIDTH-1:0]        pt_pc;
  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pt_split_table_num;
  logic                                pt_activate_valid;
  warp_num_t                           pt_activate_warp_num;

  logic                                fetch_valid;
  logic                                fetch_ready;
  warp_num_t                           fetch_warp_num;
  pc_t                                 fetch_pc;
  split_table_num_t                    fetch_split_table_num;

  // master: PC table plus fetch stage; slave: the scheduler
  modport master (
    output pt_valid, pt_pc, pt_split_table_num, pt_activate_valid, pt_activate_warp_num,
    output fetch_ready,
    input  fetch_valid, fetch_warp_num, fetch_pc, fetch_split_table_num
  );

  modport slave (
    input  pt_valid, pt_pc, pt_split_table_num, pt_activate_valid, pt_activate_warp_num,
    input  fetch_ready,
    output fetch_valid, fetch_warp_num, fetch_pc, fetch_split_table_num
  );

endinterface

// File: rtl/gelato_rr_arbiter.sv
// rtl/gelato_rr_arbiter.sv - combinational rotate-priority round-robin arbiter
module gelato_rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant
);

  logic [W-1:0] idx;

  // Walk from the farthest offset down so the request nearest ptr is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + W'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// rtl/gelato_fetch_scheduler.sv - round-robin warp picker feeding the instruction-fetch stage
module gelato_fetch_scheduler
  import gelato_types::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  gelato_fetch_scheduler_if.slave  bus,
  output logic [WARP_NUM-1:0]      parked
);

  warp_num_t           rr_ptr;
  fetch_req_t          req_q;
  fetch_req_t          req_sel;
  logic                fetch_valid_q;
  logic [WARP_NUM-1:0] elig;
  logic [WARP_NUM-1:0] parked_next;
  logic                grant_valid;
  warp_num_t           grant;
  logic                slot_free;
  logic                issue;

  assign elig      = bus.pt_valid & ~parked;
  assign slot_free = ~fetch_valid_q | bus.fetch_ready;
  assign issue     = slot_free & grant_valid;

  gelato_rr_arbiter #(
    .N (WARP_NUM),
    .W (WARP_NUM_WIDTH)
  ) u_arb (
    .req         (elig),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    req_sel                 = '0;
    req_sel.warp_num        = grant;
    req_sel.pc              = bus.pt_pc[grant*PC_WIDTH +: PC_WIDTH];
    req_sel.split_table_num = bus.pt_split_table_num[grant*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
  end

  // Issue is applied after activate so a same-cycle activate of the winner cannot unpark it.
  always_comb begin
    parked_next = parked;
    if (bus.pt_activate_valid) parked_next[bus.pt_activate_warp_num] = 1'b0;
    if (issue) parked_next[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parked        <= '0;
      rr_ptr        <= '0;
      fetch_valid_q <= 1'b0;
      req_q         <= '0;
    end else if (rdy) begin
      parked <= parked_next;
      if (slot_free) begin
        fetch_valid_q <= grant_valid;
        if (grant_valid) begin
          req_q  <= req_sel;
          rr_ptr <= grant + warp_num_t'(1);
        end
      end
    end
  end

  assign bus.fetch_valid           = fetch_valid_q;
  assign bus.fetch_warp_num        = req_q.warp_num;
  assign bus.fetch_pc              = req_q.pc;
  assign bus.fetch_split_table_num = req_q.split_table_num;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// tb/tb_gelato_fetch_scheduler.sv - directed self-checking bench for gelato_fetch_scheduler
module tb_gelato_fetch_scheduler;
  import gelato_types::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic [WARP_NUM-1:0] parked;
  int tests = 0;
  int fails = 0;

  gelato_fetch_scheduler_if b();

  gelato_fetch_scheduler dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rdy    (rdy),
    .bus    (b.slave),
    .parked (parked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input int w, input logic [31:0] v);
    b.pt_pc[w*PC_WIDTH +: PC_WIDTH] = v;
  endtask

  task automatic act(input logic v, input logic [2:0] w);
    b.pt_activate_valid    = v;
    b.pt_activate_warp_num = w;
  endtask

  task automatic chk_req(input string tag, input logic [2:0] w, input logic [31:0] pc,
                         input logic [4:0] sp);
    chk({tag, ".valid"}, 64'(b.fetch_valid), 64'd1);
    chk({tag, ".warp"}, 64'(b.fetch_warp_num), 64'(w));
    chk({tag, ".pc"}, 64'(b.fetch_pc), 64'(pc));
    chk({tag, ".split"}, 64'(b.fetch_split_table_num), 64'(sp));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    b.pt_valid    = '0;
    b.fetch_ready = 1'b0;
    act(1'b0, 3'd0);
    for (int i = 0; i < WARP_NUM; i++) begin
      set_pc(i, 32'h1000 + 32'(i) * 32'h10);
      b.pt_split_table_num[i*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH] = 5'(i + 1);
    end
    step();
    step();
    chk("rst.valid", 64'(b.fetch_valid), 64'd0);
    chk("rst.parked", 64'(parked), 64'd0);
    chk("rst.warp", 64'(b.fetch_warp_num), 64'd0);
    chk("rst.pc", 64'(b.fetch_pc), 64'd0);
    chk("rst.split", 64'(b.fetch_split_table_num), 64'd0);

    // all warps eligible, back-to-back issue 0..7
    rst_n = 1'b1;
    b.pt_valid    = 8'hFF;
    b.fetch_ready = 1'b1;
    for (int k = 0; k < WARP_NUM; k++) begin
      step();
      chk_req("rr", 3'(k), 32'h1000 + 32'(k) * 32'h10, 5'(k + 1));
      chk("rr.parked", 64'(parked), 64'((1 << (k + 1)) - 1));
    end
    step();
    chk("drain.valid", 64'(b.fetch_valid), 64'd0);
    chk("drain.parked", 64'(parked), 64'hFF);
    chk("drain.hold_warp", 64'(b.fetch_warp_num), 64'd7);

    // release warps 2 and 5 with new PCs
    set_pc(2, 32'h1040);
    set_pc(5, 32'h2000);
    act(1'b1, 3'd2);
    step();
    chk("act2.valid", 64'(b.fetch_valid), 64'd0);
    chk("act2.parked", 64'(parked), 64'hFB);
    act(1'b1, 3'd5);
    step();
    chk_req("re2", 3'd2, 32'h1040, 5'd3);
    chk("re2.parked", 64'(parked), 64'hDF);
    act(1'b0, 3'd0);
    step();
    chk_req("re5", 3'd5, 32'h2000, 5'd6);
    chk("re5.parked", 64'(parked), 64'hFF);

    // rr_ptr at 6: with 4 and 7 both free, 7 wins first
    b.pt_valid = 8'h00;
    act(1'b1, 3'd4);
    step();
    chk("ptr6.idle", 64'(b.fetch_valid), 64'd0);
    act(1'b1, 3'd7);
    step();
    chk("ptr6.parked", 64'(parked), 64'h6F);
    act(1'b0, 3'd0);
    b.pt_valid = 8'hFF;
    step();
    chk("ptr6.first", 64'(b.fetch_warp_num), 64'd7);
    step();
    chk("ptr6.second", 64'(b.fetch_warp_num), 64'd4);
    chk("ptr6.parked_all", 64'(parked), 64'hFF);

    // backpressure: request held stable while the PC table moves on
    b.pt_valid = 8'h00;
    act(1'b1, 3'd0);
    step();
    chk("hold.unpark", 64'(parked), 64'hFE);
    act(1'b0, 3'd0);
    b.pt_valid    = 8'h01;
    b.fetch_ready = 1'b0;
    set_pc(0, 32'h100);
    step();
    chk_req("hold.issue", 3'd0, 32'h100, 5'd1);
    set_pc(0, 32'h104);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_req("hold.stall", 3'd0, 32'h100, 5'd1);
    end
    b.fetch_ready = 1'b1;
    step();
    chk("hold.accept_valid", 64'(b.fetch_valid), 64'd0);
    chk("hold.accept_pc", 64'(b.fetch_pc), 64'h100);

    // activate and issue of warp 3 in the same cycle: issue wins
    b.pt_valid = 8'h00;
    act(1'b1, 3'd3);
    step();
    chk("w3.unpark", 64'(parked), 64'hF7);
    b.pt_valid = 8'h08;
    step();
    chk_req("w3.issue", 3'd3, 32'h1030, 5'd4);
    chk("w3.parked", 64'(parked), 64'hFF);

    // rdy low freezes everything, even with ready and activate asserted
    act(1'b1, 3'd1);
    b.pt_valid = 8'hFF;
    rdy = 1'b0;
    step();
    step();
    chk_req("frz", 3'd3, 32'h1030, 5'd4);
    chk("frz.parked", 64'(parked), 64'hFF);
    rdy = 1'b1;
    act(1'b0, 3'd0);
    b.pt_valid = 8'h00;
    step();
    chk("frz.accept_once", 64'(b.fetch_valid), 64'd0);
    chk("frz.parked_after", 64'(parked), 64'hFF);
    act(1'b1, 3'd0);
    step();
    act(1'b1, 3'd5);
    step();
    act(1'b0, 3'd0);
    b.pt_valid = 8'hFF;
    step();
    chk("frz.ptr_kept", 64'(b.fetch_warp_num), 64'd5);

    // reset mid-handshake
    rst_n = 1'b0;
    b.pt_valid = 8'h00;
    step();
    rst_n = 1'b1;
    b.pt_valid    = 8'h0F;
    b.fetch_ready = 1'b0;
    step();
    b.fetch_ready = 1'b1;
    step();
    step();
    step();
    chk("mrst.pre_valid", 64'(b.fetch_valid), 64'd1);
    chk("mrst.pre_parked", 64'(parked), 64'h0F);
    chk("mrst.pre_warp", 64'(b.fetch_warp_num), 64'd3);
    rst_n = 1'b0;
    step();
    chk("mrst.valid", 64'(b.fetch_valid), 64'd0);
    chk("mrst.parked", 64'(parked), 64'd0);
    chk("mrst.pc", 64'(b.fetch_pc), 64'd0);
    rst_n = 1'b1;
    b.pt_valid = 8'hFF;
    step();
    chk("mrst.first_grant", 64'(b.fetch_warp_num), 64'd0);
    chk("mrst.first_valid", 64'(b.fetch_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
